// File: rtl/major_state.sv
// Major/minor state sequencer for a PDP-8 style processor: fetch, defer and
// execute cycles of four minor states each, plus a halt state.
//
// state | meaning
// F0-F3 | fetch cycle, instruction latched at end of F1, decoded at F3
// D0-D3 | defer cycle, indirect address fetch
// E0-E3 | execute cycle for memory-reference opcodes 0-4
// H0    | halted, waiting for CONTINUE
module major_state (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic        cont,
  input  logic        sw_halt,
  input  logic        sw_sstep,
  output logic [3:0]  state,
  output logic        run,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    F0 = 4'd0,  F1 = 4'd1,  F2 = 4'd2,  F3 = 4'd3,
    D0 = 4'd4,  D1 = 4'd5,  D2 = 4'd6,  D3 = 4'd7,
    E0 = 4'd8,  E1 = 4'd9,  E2 = 4'd10, E3 = 4'd11,
    H0 = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   eoi_q, eoi_d;

  logic [2:0] opcode;
  logic       indirect;
  logic       mri;
  logic       exec_op;
  logic       hlt;
  logic       stop_req;
  state_t     after_end;

  assign opcode   = instruction[0:2];
  assign indirect = instruction[3];
  assign mri      = (opcode <= 3'd5);
  assign exec_op  = (opcode <= 3'd4);
  assign hlt      = (instruction[0:3] == 4'b1111) && instruction[10] && !instruction[11];

  // Switches are only looked at here, so a mid-instruction flip cannot cut it short.
  assign stop_req  = sw_halt || sw_sstep || ((state_q == F3) && hlt);
  assign after_end = stop_req ? H0 : F0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= H0;
      eoi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eoi_q   <= eoi_d;
    end
  end

  // eoi_d is resolved in the x2 state so the x3 state carries a registered
  // end-of-instruction flag that both instr_done and the x3 successor use.
  always_comb begin
    state_d = H0;
    eoi_d   = 1'b0;
    case (state_q)
      H0: state_d = (cont && !sw_halt) ? F0 : H0;
      F0: state_d = F1;
      F1: state_d = F2;
      F2: begin
        state_d = F3;
        eoi_d   = !(mri && indirect) && !exec_op;
      end
      F3: begin
        if (eoi_q)
          state_d = after_end;
        else if (mri && indirect)
          state_d = D0;
        else
          state_d = E0;
      end
      D0: state_d = D1;
      D1: state_d = D2;
      D2: begin
        state_d = D3;
        eoi_d   = !exec_op;
      end
      D3: state_d = eoi_q ? after_end : E0;
      E0: state_d = E1;
      E1: state_d = E2;
      E2: begin
        state_d = E3;
        eoi_d   = 1'b1;
      end
      E3: state_d = after_end;
      default: state_d = H0;
    endcase
  end

  assign state      = state_q;
  assign run        = (state_q != H0);
  assign instr_done = eoi_q && ((state_q == F3) || (state_q == D3) || (state_q == E3));

endmodule

// File: doc/major_state.md
MAJOR_STATE -- requirements
Module: major_state

Interface
REQ-001 clk  input  1  system clock; every state transition occurs on its rising edge.
REQ-002 reset  input  1  reset; one clock; synchronous, active-high.
REQ-003 instruction  input  [0:11]  current instruction, latched by the datapath at the end of F1; valid during F2 and F3.
REQ-004 cont  input  1  front-panel CONTINUE; single-cycle pulse.
REQ-005 sw_halt  input  1  front-panel HALT switch; level.
REQ-006 sw_sstep  input  1  front-panel SINGLE STEP switch; level.
REQ-007 state  output  [3:0]  major/minor state: F0-F3=0-3, D0-D3=4-7, E0-E3=8-11, H0=12.
REQ-008 run  output  1  high whenever state is not H0.
REQ-009 instr_done  output  1  one-cycle pulse in the final state of each instruction.

Function
REQ-010 Each state SHALL last exactly one clk; minor order within a major cycle SHALL be x0->x1->x2->x3.
REQ-011 state SHALL be a registered output; run and instr_done SHALL be decoded from registered state and the registered end-of-instruction condition, with no combinational path from cont or the switches.
REQ-012 Decode: opcode = instruction[0:2]; MRI = opcode 0-5; indirect = instruction[3].
REQ-013 The F3 successor SHALL be D0 if MRI and indirect; else E0 if opcode 0-4; else end-of-instruction.
REQ-014 This covers JMP direct (opcode 5, instruction[3]=0), IOT (6) and OPR (7).
REQ-015 The D3 successor SHALL be E0 if opcode 0-4; for JMP indirect it SHALL be end-of-instruction.
REQ-016 E3 SHALL always be end-of-instruction.
REQ-017 Cycle counts: OPR/IOT/JMP-direct 4 clocks; JMP-indirect 8; direct MRI 0-4 8; indirect MRI 0-4 12.
REQ-018 HLT SHALL be detected at F3 when instruction[0:3]=1111, instruction[11]=0 and instruction[10]=1 (e.g. 7402, 7602); it SHALL force the halt path.
REQ-019 At end-of-instruction, next state SHALL be H0 if sw_halt, sw_sstep or HLT-detected; else F0.
REQ-020 instr_done SHALL be high during that final state (F3, D3 or E3) only.
REQ-021 sw_halt and sw_sstep SHALL be sampled only at end-of-instruction. Asserting either mid-instruction SHALL NOT shorten the instruction.
REQ-022 In H0: cont=1 and sw_halt=0 SHALL give F0 next cycle.
REQ-023 In H0: cont with sw_halt=1 SHALL be ignored, and state SHALL remain H0.
REQ-024 cont with sw_sstep=1 SHALL run exactly one instruction, then return to H0.
REQ-025 cont while run=1 SHALL be ignored.
REQ-026 Instruction bits SHALL be ignored in H0 and in F0/F1.
REQ-027 Encodings 13-15 SHALL be unreachable; if entered, next state SHALL be H0.

Reset
REQ-028 reset=1 SHALL force state=H0 (12), run=0 and instr_done=0 on the next edge, overriding cont and any in-progress instruction.
REQ-029 reset asserted mid-instruction (e.g. during E1) SHALL abandon that instruction, with no instr_done pulse.
REQ-030 After reset deassertion the block SHALL stay in H0 until a qualifying cont.

Verification
REQ-031 Reset, then cont, with instruction=7240 (CLA CMA): state 12,0,1,2,3,0; instr_done high only at state 3; run high from the first F0.
REQ-032 instruction=1205 (TAD direct): F0-F3,E0-E3 then F0, 8 clocks; with 1605 (TAD I): F0-F3,D0-D3,E0-E3, 12 clocks, instr_done only at E3.
REQ-033 JMP sequences: 5205 -> F0-F3 then F0; 5605 -> F0-F3,D0-D3 then F0, no E states.
REQ-034 Halt sequences: instruction=7402 -> F0-F3 then H0, run=0.
REQ-035 Halt sequences: sw_halt raised during E1 of 3210 -> E2,E3 complete, then H0.
REQ-036 Halt sequences: subsequent cont with sw_halt still 1 -> remains H0.
REQ-037 sw_sstep=1, two cont pulses with 7001 -> each pulse yields exactly F0-F3 then H0.
REQ-038 Reset asserted during D2 of 1605 -> state=12 next edge, no instr_done; cont during run is ignored.
